// File: rtl/coin_feeder_pkg.sv
// Shared coin codes and output-FSM state encoding for the coin feeder.
package coin_feeder_pkg;

   localparam logic [1:0] COIN_NONE = 2'b00;
   localparam logic [1:0] COIN_A    = 2'b01;
   localparam logic [1:0] COIN_B    = 2'b10;
   localparam logic [1:0] COIN_C    = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2
   } feed_state_e;

endpackage

// File: rtl/coin_fifo.sv
// Small synchronous FIFO of 2-bit coin codes; push and pop may coincide when full.
module coin_fifo #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             push,
   input  logic                             pop,
   input  logic [1:0]                       wdata,
   output logic [1:0]                       rdata,
   output logic                             full,
   output logic                             empty,
   output logic [$clog2(DEPTH+1)-1:0]       level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = $clog2(DEPTH+1);

   logic [1:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_q;
   logic [AW-1:0] rd_q;
   logic [LW-1:0] cnt_q;
   logic          do_push;
   logic          do_pop;

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == LW'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem_q[rd_q];
   assign level   = cnt_q;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_q] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + AW'(1);
         if (do_pop)  rd_q <= rd_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + LW'(1);
            2'b01:   cnt_q <= cnt_q - LW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/coin_feeder.sv
// Coin-acceptor front end: qualifies slot-sensor pulses, queues coins and
// emits them as single-cycle codes on d, paced by GAP idle cycles and x1/x2.
module coin_feeder
   import coin_feeder_pkg::*;
#(
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned MIN_PULSE = 3,
   parameter int unsigned GAP       = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          coin_a,
   input  logic                          coin_b,
   input  logic                          coin_c,
   input  logic                          x1,
   input  logic                          x2,
   output logic [1:0]                    d,
   output logic                          coin_reject,
   output logic                          full,
   output logic [$clog2(DEPTH+1)-1:0]    level
);

   localparam int unsigned CW = $clog2(MIN_PULSE+1);
   localparam int unsigned GW = $clog2(GAP+1);

   logic [2:0]    sense;
   logic [2:0]    qual_ev;
   logic          single_ev;
   logic          jam_ev;
   logic [1:0]    ev_code;
   logic          pop;
   logic          fifo_empty;
   logic          fifo_full;
   logic [1:0]    head;

   feed_state_e   state_q, state_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [1:0]    d_q, d_d;
   logic          reject_q, reject_d;

   assign sense = {coin_c, coin_b, coin_a};

   // A sensor held high through reset stays disarmed until it is seen low.
   for (genvar g = 0; g < 3; g++) begin : g_qual
      logic [CW-1:0] cnt_q;
      logic          armed_q;

      assign qual_ev[g] = sense[g] && armed_q && (cnt_q == CW'(MIN_PULSE-1));

      always_ff @(posedge clk) begin
         if (rst) begin
            cnt_q   <= '0;
            armed_q <= ~sense[g];
         end else if (!sense[g]) begin
            cnt_q   <= '0;
            armed_q <= 1'b1;
         end else begin
            if (cnt_q != CW'(MIN_PULSE)) cnt_q <= cnt_q + CW'(1);
            if (qual_ev[g]) armed_q <= 1'b0;
         end
      end
   end

   assign single_ev = $onehot(qual_ev);
   assign jam_ev    = (qual_ev != '0) && !single_ev;

   always_comb begin
      ev_code = COIN_NONE;
      if (qual_ev[0])      ev_code = COIN_A;
      else if (qual_ev[1]) ev_code = COIN_B;
      else if (qual_ev[2]) ev_code = COIN_C;
   end

   assign pop      = (state_q == ST_IDLE) && !fifo_empty && !x1 && !x2;
   assign reject_d = jam_ev || (single_ev && fifo_full && !pop);

   coin_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (single_ev),
      .pop   (pop),
      .wdata (ev_code),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (level)
   );

   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      d_d     = COIN_NONE;
      case (state_q)
         ST_IDLE: begin
            if (pop) begin
               state_d = ST_SEND;
               d_d     = head;
            end
         end
         ST_SEND: begin
            state_d = ST_GAP;
            gap_d   = '0;
         end
         ST_GAP: begin
            if (gap_q == GW'(GAP-1)) state_d = ST_IDLE;
            else                     gap_d   = gap_q + GW'(1);
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         gap_q    <= '0;
         d_q      <= COIN_NONE;
         reject_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         gap_q    <= gap_d;
         d_q      <= d_d;
         reject_q <= reject_d;
      end
   end

   assign d           = d_q;
   assign coin_reject = reject_q;
   assign full        = fifo_full;

endmodule

// File: tb/tb_coin_feeder.sv
// Self-checking bench for coin_feeder: directed scenarios plus random sensor
// and inhibit activity, checked every cycle against a queue-based reference.
module tb_coin_feeder;

   localparam int unsigned DEPTH     = 4;
   localparam int unsigned MIN_PULSE = 3;
   localparam int unsigned GAP       = 1;

   logic                          clk = 1'b0;
   logic                          rst = 1'b1;
   logic [2:0]                    sens = '0;
   logic                          x1 = 1'b0;
   logic                          x2 = 1'b0;
   logic [1:0]                    d;
   logic                          coin_reject;
   logic                          full;
   logic [$clog2(DEPTH+1)-1:0]    level;

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   int mq[$];
   int run[3];
   bit seen_low[3];
   int since_pop = GAP + 2;
   int exp_d = 0;
   int exp_rej = 0;

   coin_feeder #(
      .DEPTH     (DEPTH),
      .MIN_PULSE (MIN_PULSE),
      .GAP       (GAP)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .coin_a      (sens[0]),
      .coin_b      (sens[1]),
      .coin_c      (sens[2]),
      .x1          (x1),
      .x2          (x2),
      .d           (d),
      .coin_reject (coin_reject),
      .full        (full),
      .level       (level)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, expv, $time);
      end
   endtask

   // One clock edge of the specified behaviour, in terms of pulse lengths and a coin queue.
   task automatic model_edge();
      int nev;
      int code;
      bit do_pop;
      if (rst) begin
         mq.delete();
         for (int i = 0; i < 3; i++) begin
            run[i]      = 0;
            seen_low[i] = !sens[i];
         end
         since_pop = GAP + 2;
         exp_d     = 0;
         exp_rej   = 0;
         return;
      end
      nev  = 0;
      code = 0;
      for (int i = 0; i < 3; i++) begin
         if (sens[i]) begin
            run[i]++;
            if (seen_low[i] && run[i] == MIN_PULSE) begin
               nev++;
               code = i + 1;
            end
         end else begin
            run[i]      = 0;
            seen_low[i] = 1'b1;
         end
      end
      if (since_pop < 1000) since_pop++;
      do_pop = (since_pop >= GAP + 2) && (mq.size() > 0) && !x1 && !x2;
      exp_d = 0;
      if (do_pop) begin
         exp_d     = mq.pop_front();
         since_pop = 0;
      end
      exp_rej = 0;
      if (nev > 1) begin
         exp_rej = 1;
      end else if (nev == 1) begin
         if (mq.size() < DEPTH) mq.push_back(code);
         else                   exp_rej = 1;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check("d", 32'(d), 32'(exp_d));
      check("coin_reject", 32'(coin_reject), 32'(exp_rej));
      check("level", 32'(level), 32'(mq.size()));
      check("full", 32'(full), 32'(mq.size() == DEPTH));
   endtask

   task automatic cycles(input int n);
      repeat (n) step();
   endtask

   task automatic coin(input int idx);
      sens = 3'(1 << idx);
      cycles(MIN_PULSE + 1);
      sens = '0;
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int nz;
      int rj;
      int first;
      int peak;
      int seq[10];
      int exp_seq[10];
      bit found;

      exp_seq = '{1, 0, 0, 2, 0, 0, 3, 0, 0, 1};

      // Reset held with coin_b high; no code until coin_b is seen low.
      rst  = 1'b1;
      sens = 3'b010;
      cycles(2);
      check("rst_d", 32'(d), 0);
      check("rst_level", 32'(level), 0);
      check("rst_full", 32'(full), 0);
      check("rst_reject", 32'(coin_reject), 0);
      rst = 1'b0;
      nz  = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (d != 2'b00) nz++;
      end
      check("rst_held_no_code", nz, 0);
      sens = '0;
      step();

      // Single coin B held 10 cycles.
      sens  = 3'b010;
      nz    = 0;
      first = -1;
      peak  = 0;
      for (int i = 1; i <= 10; i++) begin
         step();
         if (d == 2'b10) begin
            nz++;
            if (first < 0) first = i;
         end
         if (int'(level) > peak) peak = int'(level);
      end
      sens = '0;
      cycles(3);
      check("single_count", nz, 1);
      check("single_latency", first, 4);
      check("single_peak", peak, 1);
      check("single_level_end", 32'(level), 0);

      // Glitch shorter than MIN_PULSE.
      sens = 3'b001;
      nz   = 0;
      rj   = 0;
      peak = 0;
      cycles(2);
      sens = '0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (d != 2'b00) nz++;
         if (coin_reject) rj++;
         if (int'(level) > peak) peak = int'(level);
      end
      check("glitch_no_code", nz, 0);
      check("glitch_no_reject", rj, 0);
      check("glitch_level", peak, 0);

      // Overflow under inhibit, then ordered drain.
      x1 = 1'b1;
      rj = 0;
      foreach (exp_seq[k]) if (k < 5) begin
         sens = 3'(1 << (k % 3));
         for (int i = 0; i < MIN_PULSE + 1; i++) begin
            step();
            if (coin_reject) rj++;
         end
         sens = '0;
         step();
         if (coin_reject) rj++;
      end
      check("ovf_level", 32'(level), 4);
      check("ovf_full", 32'(full), 1);
      check("ovf_rejects", rj, 1);
      x1 = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         seq[i] = int'(d);
      end
      for (int i = 0; i < 10; i++) check($sformatf("drain_seq%0d", i), seq[i], exp_seq[i]);
      cycles(3);
      check("drain_level_end", 32'(level), 0);

      // Jam: A and C qualify on the same edge.
      sens = 3'b101;
      nz   = 0;
      rj   = 0;
      for (int i = 0; i < MIN_PULSE + 3; i++) begin
         step();
         if (d != 2'b00) nz++;
         if (coin_reject) rj++;
      end
      sens = '0;
      cycles(2);
      check("jam_reject", rj, 1);
      check("jam_no_code", nz, 0);
      check("jam_level", 32'(level), 0);

      // Reset during SEND discards the queue.
      x1 = 1'b1;
      coin(0);
      coin(1);
      coin(2);
      check("mid_level", 32'(level), 3);
      x1    = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 6 && !found; i++) begin
         step();
         if (d != 2'b00) found = 1'b1;
      end
      check("mid_send_seen", 32'(found), 1);
      rst = 1'b1;
      step();
      check("mid_rst_d", 32'(d), 0);
      check("mid_rst_level", 32'(level), 0);
      rst = 1'b0;
      nz  = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (d != 2'b00) nz++;
      end
      check("mid_no_codes", nz, 0);

      // Random sensor, inhibit and occasional reset activity.
      for (int i = 0; i < 2000; i++) begin
         for (int s = 0; s < 3; s++) begin
            if ($urandom_range(0, 3) == 0) sens[s] = ~sens[s];
         end
         x1  = ($urandom_range(0, 9) == 0);
         x2  = ($urandom_range(0, 11) == 0);
         rst = ($urandom_range(0, 299) == 0);
         step();
      end
      rst  = 1'b0;
      sens = '0;
      x1   = 1'b0;
      x2   = 1'b0;
      cycles(20);
      check("final_level", 32'(level), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
